hit_word_serializer: RTL and testbench

//  Reader side of the data-concentrator hit FIFO. Pops 64-bit hit words
//  {source[3:0],counter[3:0],column[7:0],ToT[5:0],TS[9:0],row[7:0],TrigIdx[7:0],TrigTS[15:0]}
//  and serializes each into 8 bytes, MSB first, on a valid/ready byte stream to the datamux/USB path.

---
 rtl/hit_word_serializer.sv | 103 ++++++++++
 tb/tb_hit_word_serializer.sv | 351 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hit_word_serializer.sv
// rtl/hit_word_serializer.sv - pops hit words from the read side of the hit FIFO and streams them MSB byte first
module hit_word_serializer #(
  parameter int WORD_W = 64,
  parameter int CNT_W  = 16
) (
  input  logic              rd_clk,
  input  logic              rst_n,
  input  logic              enable,
  input  logic [15:0]       source_mask,
  input  logic [WORD_W-1:0] fifo_dout,
  input  logic              fifo_empty,
  output logic              fifo_rd_en,
  output logic [7:0]        dout,
  output logic              dout_valid,
  output logic              dout_last,
  input  logic              dout_ready,
  output logic              busy,
  output logic [CNT_W-1:0]  sent_cnt,
  output logic [CNT_W-1:0]  drop_cnt
);

  localparam int NBYTES = WORD_W / 8;
  localparam int IDX_W  = (NBYTES > 1) ? $clog2(NBYTES) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NBYTES - 1);

  typedef enum logic [1:0] {IDLE, FETCH, SEND} state_t;

  state_t            state;
  logic [WORD_W-1:0] shreg;
  logic [IDX_W-1:0]  idx;
  logic              pop;
  logic              keep;
  logic              last_accept;

  // rst_n is folded in so no pop can slip out while the block is held in reset
  assign pop         = enable & ~fifo_empty & rst_n;
  // source field sits in the top nibble of the word presented in FETCH
  assign keep        = source_mask[fifo_dout[WORD_W-1 -: 4]];
  assign last_accept = dout_valid & dout_ready & (idx == LAST_IDX);
  assign busy        = (state != IDLE);

  // Pop strobe: start from idle, chain after a dropped word, or chain on the handshake of the final byte
  always_comb begin
    fifo_rd_en = 1'b0;
    case (state)
      IDLE:    fifo_rd_en = pop;
      FETCH:   fifo_rd_en = pop & ~keep;
      SEND:    fifo_rd_en = pop & last_accept;
      default: fifo_rd_en = 1'b0;
    endcase
  end

  // Word sequencer: filter in FETCH, then walk the bytes out under valid/ready with outputs held on stall
  always_ff @(posedge rd_clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      shreg      <= '0;
      idx        <= '0;
      dout       <= '0;
      dout_valid <= 1'b0;
      dout_last  <= 1'b0;
      sent_cnt   <= '0;
      drop_cnt   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (pop) state <= FETCH;
        end
        FETCH: begin
          if (keep) begin
            // shreg keeps only the bytes still to be sent, so the next byte is always its top byte
            shreg      <= fifo_dout << 8;
            idx        <= '0;
            dout       <= fifo_dout[WORD_W-1 -: 8];
            dout_valid <= 1'b1;
            dout_last  <= (NBYTES == 1);
            state      <= SEND;
          end else begin
            drop_cnt <= drop_cnt + 1'b1;
            state    <= pop ? FETCH : IDLE;
          end
        end
        SEND: begin
          if (dout_valid && dout_ready) begin
            if (idx != LAST_IDX) begin
              shreg     <= shreg << 8;
              idx       <= idx + 1'b1;
              dout      <= shreg[WORD_W-1 -: 8];
              dout_last <= ((idx + 1'b1) == LAST_IDX);
            end else begin
              sent_cnt   <= sent_cnt + 1'b1;
              dout_valid <= 1'b0;
              dout_last  <= 1'b0;
              state      <= pop ? FETCH : IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_hit_word_serializer.sv
// tb/tb_hit_word_serializer.sv - directed bench with byte-stream scoreboard for hit_word_serializer
module tb_hit_word_serializer;

  typedef struct {
    logic [7:0] b;
    logic       last;
  } exp_t;

  logic        rd_clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        enable = 1'b0;
  logic        fifo_empty = 1'b1;
  logic        dout_ready = 1'b1;
  logic [15:0] source_mask = 16'hFFFF;
  logic [63:0] fifo_dout = '0;
  logic        fifo_rd_en;
  logic        dout_valid;
  logic        dout_last;
  logic        busy;
  logic [7:0]  dout;
  logic [15:0] sent_cnt;
  logic [15:0] drop_cnt;

  int n_tests = 0;
  int n_fail = 0;
  int cyc = 0;

  logic [63:0] fifo_q[$];
  exp_t        exp_q[$];
  logic [7:0]  log_b[$];
  logic        log_l[$];
  int          pop_cycs[$];
  int          acc_cycs[$];
  int          exp_sent = 0;
  int          exp_drop = 0;
  int          last_pop_cyc = 0;
  int          first_lat = -1;
  logic        prev_stall = 1'b0;
  logic        prev_valid = 1'b0;
  logic [7:0]  prev_dout = '0;
  logic        prev_last = 1'b0;
  logic [63:0] mon_w;
  exp_t        mon_e;
  logic [63:0] tw;

  logic [7:0]  t2_bytes [8] = '{8'h12, 8'h34, 8'h56, 8'h78, 8'h9A, 8'hBC, 8'hDE, 8'hF0};
  logic [63:0] w3 [4] = '{64'hA011_2233_4455_6677, 64'hB08899AABBCCDDEE,
                          64'hC0F0_E1D2_C3B4_A596, 64'h0F01_0203_0405_0607};

  hit_word_serializer #(.WORD_W(64), .CNT_W(16)) dut (
    .rd_clk      (rd_clk),
    .rst_n       (rst_n),
    .enable      (enable),
    .source_mask (source_mask),
    .fifo_dout   (fifo_dout),
    .fifo_empty  (fifo_empty),
    .fifo_rd_en  (fifo_rd_en),
    .dout        (dout),
    .dout_valid  (dout_valid),
    .dout_last   (dout_last),
    .dout_ready  (dout_ready),
    .busy        (busy),
    .sent_cnt    (sent_cnt),
    .drop_cnt    (drop_cnt)
  );

  always #5 rd_clk = ~rd_clk;

  always @(posedge rd_clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // FIFO model, standard mode: data appears the cycle after the pop
  always @(posedge rd_clk) begin
    if (rst_n && fifo_rd_en && fifo_q.size() > 0) fifo_dout <= fifo_q.pop_front();
  end

  always @(posedge rd_clk) begin
    #1;
    fifo_empty = (fifo_q.size() == 0);
  end

  // Scoreboard: every popped word either becomes 8 expected bytes or one expected drop
  always @(negedge rd_clk) begin
    if (!rst_n) begin
      exp_q.delete();
      exp_sent = 0;
      exp_drop = 0;
      prev_stall = 1'b0;
      prev_valid = 1'b0;
      check("reset_rd_en", 64'(fifo_rd_en), 64'd0);
      check("reset_valid", 64'(dout_valid), 64'd0);
    end else begin
      if (fifo_rd_en) begin
        check("rd_en_not_empty", 64'(fifo_empty), 64'd0);
        pop_cycs.push_back(cyc);
        last_pop_cyc = cyc;
        if (fifo_q.size() > 0) begin
          mon_w = fifo_q[0];
          if (source_mask[mon_w[63:60]]) begin
            for (int i = 0; i < 8; i++) begin
              mon_e.b = mon_w[63-8*i -: 8];
              mon_e.last = (i == 7);
              exp_q.push_back(mon_e);
            end
          end else begin
            exp_drop++;
          end
        end
      end
      if (prev_stall) begin
        check("hold_valid", 64'(dout_valid), 64'd1);
        check("hold_dout", 64'(dout), 64'(prev_dout));
        check("hold_last", 64'(dout_last), 64'(prev_last));
      end
      if (dout_valid) begin
        if (!prev_valid) first_lat = cyc - last_pop_cyc;
        if (exp_q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL unexpected_byte: got 0x%0h, expected no byte", dout);
        end else begin
          check("byte", 64'(dout), 64'(exp_q[0].b));
          check("last", 64'(dout_last), 64'(exp_q[0].last));
          if (dout_ready) begin
            if (exp_q[0].last) exp_sent++;
            void'(exp_q.pop_front());
            log_b.push_back(dout);
            log_l.push_back(dout_last);
            acc_cycs.push_back(cyc);
          end
        end
      end
      prev_stall = dout_valid && !dout_ready;
      prev_valid = dout_valid;
      prev_dout  = dout;
      prev_last  = dout_last;
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge rd_clk);
    #2;
  endtask

  task automatic push(input logic [63:0] w);
    fifo_q.push_back(w);
    fifo_empty = 1'b0;
  endtask

  task automatic clear_logs();
    log_b.delete();
    log_l.delete();
    pop_cycs.delete();
    acc_cycs.delete();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    step(2);
    rst_n = 1'b1;
    step(1);
  endtask

  task automatic wait_quiet(input string name, input int limit);
    int k = 0;
    step(1);
    while (!(!busy && (fifo_empty || !enable)) && k < limit) begin
      step(1);
      k++;
    end
    check({name, "_idle"}, 64'(busy), 64'd0);
    check({name, "_sb_empty"}, 64'(exp_q.size()), 64'd0);
  endtask

  task automatic wait_log(input string name, input int n, input int limit);
    int k = 0;
    while (log_b.size() < n && k < limit) begin
      step(1);
      k++;
    end
    check({name, "_reached"}, 64'(log_b.size() >= n), 64'd1);
  endtask

  task automatic check_model_cnt(input string name);
    check({name, "_sent_model"}, 64'(sent_cnt), 64'(exp_sent[15:0]));
    check({name, "_drop_model"}, 64'(drop_cnt), 64'(exp_drop[15:0]));
  endtask

  initial begin
    #1500000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    // 1: reset held with a non-empty FIFO
    enable = 1'b1;
    push(64'h1111_2222_3333_4444);
    push(64'h5555_6666_7777_8888);
    step(3);
    check("t1_rd_en", 64'(fifo_rd_en), 64'd0);
    check("t1_valid", 64'(dout_valid), 64'd0);
    check("t1_last", 64'(dout_last), 64'd0);
    check("t1_dout", 64'(dout), 64'd0);
    check("t1_busy", 64'(busy), 64'd0);
    check("t1_sent", 64'(sent_cnt), 64'd0);
    check("t1_drop", 64'(drop_cnt), 64'd0);
    enable = 1'b0;
    fifo_q.delete();
    fifo_empty = 1'b1;
    rst_n = 1'b1;
    step(2);

    // 2: single word, latency and byte order
    clear_logs();
    enable = 1'b1;
    push(64'h1234_5678_9ABC_DEF0);
    wait_quiet("t2", 40);
    check("t2_nbytes", 64'(log_b.size()), 64'd8);
    if (log_b.size() == 8) begin
      for (int i = 0; i < 8; i++) begin
        check($sformatf("t2_byte%0d", i), 64'(log_b[i]), 64'(t2_bytes[i]));
        check($sformatf("t2_last%0d", i), 64'(log_l[i]), 64'(i == 7));
      end
      check("t2_consecutive", 64'(acc_cycs[7] - acc_cycs[0]), 64'd7);
    end
    check("t2_latency", 64'(first_lat), 64'd2);
    check("t2_sent", 64'(sent_cnt), 64'd1);
    check("t2_drop", 64'(drop_cnt), 64'd0);
    check_model_cnt("t2");

    // 3: random backpressure over 4 words
    do_reset();
    clear_logs();
    for (int i = 0; i < 4; i++) push(w3[i]);
    for (int k = 0; k < 400; k++) begin
      dout_ready = 1'($urandom_range(0, 1));
      step(1);
      if (!busy && fifo_empty) break;
    end
    dout_ready = 1'b1;
    step(1);
    check("t3_idle", 64'(busy), 64'd0);
    check("t3_nbytes", 64'(log_b.size()), 64'd32);
    if (log_b.size() == 32) begin
      for (int i = 0; i < 32; i++) begin
        tw = w3[i / 8];
        check($sformatf("t3_byte%0d", i), 64'(log_b[i]), 64'(tw[63-8*(i%8) -: 8]));
      end
    end
    check("t3_sent", 64'(sent_cnt), 64'd4);
    check_model_cnt("t3");

    // 4: source filter
    do_reset();
    clear_logs();
    source_mask = 16'h0002;
    push(64'h1A00_0000_0000_0001);
    push(64'h3B00_0000_0000_0002);
    push(64'h1C00_0000_0000_0003);
    wait_quiet("t4", 60);
    check("t4_sent", 64'(sent_cnt), 64'd2);
    check("t4_drop", 64'(drop_cnt), 64'd1);
    check("t4_model_drop", 64'(exp_drop), 64'd1);
    check("t4_nbytes", 64'(log_b.size()), 64'd16);
    if (log_b.size() == 16) begin
      check("t4_first0", 64'(log_b[0]), 64'h1A);
      check("t4_first1", 64'(log_b[8]), 64'h1C);
      check("t4_tail1", 64'(log_b[15]), 64'h03);
    end
    check_model_cnt("t4");
    source_mask = 16'hFFFF;

    // 5: streaming throughput
    do_reset();
    clear_logs();
    enable = 1'b0;
    for (int i = 0; i < 10; i++) push({4'(i), 4'h0, 56'(i * 3 + 1)});
    enable = 1'b1;
    wait_quiet("t5", 200);
    check("t5_nbytes", 64'(log_b.size()), 64'd80);
    check("t5_pops", 64'(pop_cycs.size()), 64'd10);
    if (log_b.size() == 80 && pop_cycs.size() > 0)
      check("t5_span", 64'(acc_cycs[79] - pop_cycs[0]), 64'd90);
    check("t5_sent", 64'(sent_cnt), 64'd10);
    check_model_cnt("t5");

    // 6a: enable dropped at byte 3 of a word
    do_reset();
    clear_logs();
    push(64'h2122_2324_2526_2728);
    push(64'h3132_3334_3536_3738);
    wait_log("t6a", 3, 40);
    enable = 1'b0;
    wait_quiet("t6a", 40);
    step(5);
    check("t6a_nbytes", 64'(log_b.size()), 64'd8);
    if (log_b.size() == 8) check("t6a_lastbyte", 64'(log_b[7]), 64'h28);
    check("t6a_pops", 64'(pop_cycs.size()), 64'd1);
    check("t6a_fifo_left", 64'(fifo_q.size()), 64'd1);
    check("t6a_sent", 64'(sent_cnt), 64'd1);

    // 6b: reset pulse mid-word abandons it
    clear_logs();
    push(64'h4142_4344_4546_4748);
    enable = 1'b1;
    wait_log("t6b", 3, 40);
    rst_n = 1'b0;
    enable = 1'b0;
    step(1);
    check("t6b_valid", 64'(dout_valid), 64'd0);
    check("t6b_busy", 64'(busy), 64'd0);
    check("t6b_sent", 64'(sent_cnt), 64'd0);
    rst_n = 1'b1;
    step(6);
    check("t6b_nbytes", 64'(log_b.size()), 64'd3);
    check("t6b_pops", 64'(pop_cycs.size()), 64'd1);
    check("t6b_fifo_left", 64'(fifo_q.size()), 64'd1);
    check("t6b_valid_after", 64'(dout_valid), 64'd0);
    fifo_q.delete();
    fifo_empty = 1'b1;

    // 6c: drop counter wraps 0xFFFF -> 0x0000
    do_reset();
    clear_logs();
    source_mask = 16'h0000;
    enable = 1'b1;
    for (int i = 0; i < 65535; i++) push(64'(i));
    wait_quiet("t6c", 70000);
    check("t6c_drop_ffff", 64'(drop_cnt), 64'hFFFF);
    check("t6c_sent", 64'(sent_cnt), 64'd0);
    check_model_cnt("t6c");
    push(64'h0ABC);
    wait_quiet("t6c_wrap", 20);
    check("t6c_drop_wrap", 64'(drop_cnt), 64'h0000);
    check("t6c_model_drop", 64'(exp_drop), 64'd65536);
    check("t6c_no_bytes", 64'(log_b.size()), 64'd0);
    check_model_cnt("t6c_wrap");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
